// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result handshake bundle for fp_mul_pipe
interface fp_mul_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         i_vld;
    logic         i_rdy;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic [W-1:0] o_res;
    logic         o_res_vld;
    logic         o_res_rdy;
    logic         overflow;
    logic         underflow;
    logic         inexact;
    logic         exception;

    modport master (
        output i_vld, i_a, i_b, o_res_rdy,
        input  i_rdy, o_res, o_res_vld, overflow, underflow, inexact, exception
    );

    modport slave (
        input  i_vld, i_a, i_b, o_res_rdy,
        output i_rdy, o_res, o_res_vld, overflow, underflow, inexact, exception
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - pipelined floating-point multiplier, round-to-nearest-even
module fp_mul_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    fp_mul_pipe_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW2  = EXP_W + 2;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EMAX = 2 ** EXP_W - 1;

    typedef enum logic [1:0] {
        K_NUM,
        K_ZERO,
        K_INF,
        K_NAN
    } kind_t;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;
    assign adv       = !bus.o_res_vld || bus.o_res_rdy;
    assign bus.i_rdy = adv;

    function automatic kind_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '1) begin
            return (m == '0) ? K_INF : K_NAN;
        end
        if (e == '0) begin
            return K_ZERO;
        end
        return K_NUM;
    endfunction

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    kind_t            ka, kb, in_kind;
    logic [EW2-1:0]   esum;

    assign {sa, ea, ma} = bus.i_a;
    assign {sb, eb, mb} = bus.i_b;
    assign ka   = classify(ea, ma);
    assign kb   = classify(eb, mb);
    assign esum = EW2'(ea) + EW2'(eb) - EW2'(BIAS);

    // Subnormals classify as zero, so flush-to-zero falls out of the priority chain.
    always_comb begin
        in_kind = K_NUM;
        if (ka == K_NAN || kb == K_NAN ||
            (ka == K_INF && kb == K_ZERO) || (ka == K_ZERO && kb == K_INF)) begin
            in_kind = K_NAN;
        end else if (ka == K_INF || kb == K_INF) begin
            in_kind = K_INF;
        end else if (ka == K_ZERO || kb == K_ZERO) begin
            in_kind = K_ZERO;
        end
    end

    // S1 is split in two ranks so the multiplier runs register to register.
    logic           op_vld;
    logic           op_sign;
    kind_t          op_kind;
    logic [EW2-1:0] op_exp;
    logic [MAN_W:0] op_ma, op_mb;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_vld  <= 1'b0;
            op_sign <= 1'b0;
            op_kind <= K_ZERO;
            op_exp  <= '0;
            op_ma   <= '0;
            op_mb   <= '0;
        end else if (adv) begin
            op_vld  <= bus.i_vld;
            op_sign <= sa ^ sb;
            op_kind <= in_kind;
            op_exp  <= esum;
            op_ma   <= {1'b1, ma};
            op_mb   <= {1'b1, mb};
        end
    end

    logic           s1_vld;
    logic           s1_sign;
    kind_t          s1_kind;
    logic [EW2-1:0] s1_exp;
    logic [PW-1:0]  s1_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_kind <= K_ZERO;
            s1_exp  <= '0;
            s1_prod <= '0;
        end else if (adv) begin
            s1_vld  <= op_vld;
            s1_sign <= op_sign;
            s1_kind <= op_kind;
            s1_exp  <= op_exp;
            s1_prod <= PW'(op_ma) * PW'(op_mb);
        end
    end

    logic [MAN_W-1:0] frac;
    logic             guard, sticky, rnd_up;
    logic [EW2-1:0]   nexp, rexp;
    logic [MAN_W:0]   rnd;

    always_comb begin
        frac   = s1_prod[2*MAN_W-1 -: MAN_W];
        guard  = s1_prod[MAN_W-1];
        sticky = |s1_prod[MAN_W-2:0];
        nexp   = s1_exp;
        if (s1_prod[PW-1]) begin
            frac   = s1_prod[PW-2 -: MAN_W];
            guard  = s1_prod[MAN_W];
            sticky = |s1_prod[MAN_W-1:0];
            nexp   = s1_exp + EW2'(1);
        end
        rnd_up = guard && (sticky || frac[0]);
        rnd    = {1'b0, frac} + (MAN_W+1)'(rnd_up);
        // A rounding carry leaves the fraction at zero; only the exponent moves.
        rexp   = nexp + EW2'(rnd[MAN_W]);
    end

    logic             s2_vld;
    logic             s2_sign;
    kind_t            s2_kind;
    logic [EW2-1:0]   s2_exp;
    logic [MAN_W-1:0] s2_frac;
    logic             s2_inx;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_kind <= K_ZERO;
            s2_exp  <= '0;
            s2_frac <= '0;
            s2_inx  <= 1'b0;
        end else if (adv) begin
            s2_vld  <= s1_vld;
            s2_sign <= s1_sign;
            s2_kind <= s1_kind;
            s2_exp  <= rexp;
            s2_frac <= rnd[MAN_W-1:0];
            s2_inx  <= guard | sticky;
        end
    end

    logic [W-1:0] res_n;
    logic         ovf_n, unf_n, inx_n, exc_n;
    logic         too_big, too_small;

    assign too_big   = !s2_exp[EW2-1] && (s2_exp[EW2-2:0] >= (EW2-1)'(EMAX));
    assign too_small = s2_exp[EW2-1] || (s2_exp == '0);

    always_comb begin
        res_n = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
        ovf_n = 1'b0;
        unf_n = 1'b0;
        inx_n = 1'b0;
        exc_n = 1'b0;
        case (s2_kind)
            K_NAN: begin
                res_n = QNAN;
                exc_n = 1'b1;
            end
            K_INF:  res_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            K_ZERO: res_n = {s2_sign, {(W-1){1'b0}}};
            default: begin
                if (too_big) begin
                    res_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_n = 1'b1;
                    inx_n = 1'b1;
                end else if (too_small) begin
                    res_n = {s2_sign, {(W-1){1'b0}}};
                    unf_n = 1'b1;
                    inx_n = 1'b1;
                end else begin
                    inx_n = s2_inx;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o_res_vld <= 1'b0;
            bus.o_res     <= '0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
            bus.inexact   <= 1'b0;
            bus.exception <= 1'b0;
        end else if (adv) begin
            bus.o_res_vld <= s2_vld;
            bus.o_res     <= res_n;
            bus.overflow  <= ovf_n;
            bus.underflow <= unf_n;
            bus.inexact   <= inx_n;
            bus.exception <= exc_n;
        end
    end
endmodule
